// File: rtl/parking_controller_pkg.sv
// parking_controller_pkg: shared constants and counter helpers for the parking lot controller
//   CNT_W            width of every count, capacity and vacated value
//   SHIFT_START_HOUR first hour at which free capacity starts growing
//   SHIFT_END_HOUR   hour from which free capacity stays at its maximum
//   next_count       one-cycle update of a class count from entry/exit events
//   sat_sub          capacity minus count, clamped at zero
package parking_controller_pkg;
    localparam int CNT_W            = 10;
    localparam int SHIFT_START_HOUR = 13;
    localparam int SHIFT_END_HOUR   = 16;

    // Entry and exit are judged against the same pre-cycle count, so an exit
    // frees the slot a simultaneous entry takes even when the class is full.
    function automatic logic [CNT_W-1:0] next_count(
        input logic [CNT_W-1:0] cnt,
        input logic [CNT_W-1:0] cap,
        input logic             enter,
        input logic             leave
    );
        logic out_ok;
        logic in_ok;
        out_ok = leave && cnt != '0;
        in_ok  = enter && (cnt < cap || out_ok);
        return in_ok == out_ok ? cnt : in_ok ? cnt + 1'b1 : cnt - 1'b1;
    endfunction

    // A shrinking schedule can leave count above capacity; read that as no space.
    function automatic logic [CNT_W-1:0] sat_sub(
        input logic [CNT_W-1:0] cap,
        input logic [CNT_W-1:0] cnt
    );
        return cap > cnt ? cap - cnt : '0;
    endfunction
endpackage

// File: rtl/parking_capacity_schedule.sv
// parking_capacity_schedule: hour-dependent split of the lot between free and uni cars
//   current_hour in  6      hour of day (24..63 treated like the evening)
//   free_cap     out CNT_W  free-class capacity
//   uni_cap      out CNT_W  uni capacity, the rest of the lot
module parking_capacity_schedule
    import parking_controller_pkg::*;
#(
    parameter int TOTAL_SPACE = 700,
    parameter int FREE_BASE   = 200,
    parameter int FREE_STEP   = 50
) (
    input  logic [5:0]       current_hour,
    output logic [CNT_W-1:0] free_cap,
    output logic [CNT_W-1:0] uni_cap
);
    localparam logic [CNT_W-1:0] TOTAL = CNT_W'(TOTAL_SPACE);
    localparam logic [CNT_W-1:0] BASE  = CNT_W'(FREE_BASE);
    localparam logic [CNT_W-1:0] STEP  = CNT_W'(FREE_STEP);

    logic [CNT_W-1:0] steps;

    // Number of FREE_STEP increments in force: 0 in the morning, 1..3 during
    // the afternoon shift, 4 from the end of the shift onward.
    always_comb begin
        steps    = current_hour < 6'(SHIFT_START_HOUR) ? '0 :
                   current_hour < 6'(SHIFT_END_HOUR)   ? CNT_W'(current_hour - 6'(SHIFT_START_HOUR - 1)) :
                                                         CNT_W'(SHIFT_END_HOUR - SHIFT_START_HOUR + 1);
        free_cap = BASE + STEP * steps;
        uni_cap  = TOTAL - free_cap;
    end
endmodule

// File: rtl/parking_controller.sv
// parking_controller: per-class occupancy counting and space-available signage
//   clk                  in  1   system clock
//   rst_n                in  1   asynchronous active-low reset
//   car_entered          in  1   entry level, rising edge = one entry
//   is_uni_car_entered   in  1   class of entering car (1 = uni)
//   car_exited           in  1   exit level, rising edge = one exit
//   is_uni_car_exited    in  1   class of exiting car (1 = uni)
//   current_hour         in  6   hour of day
//   uni_parked_car       out 10  uni cars parked
//   parked_car           out 10  free-class cars parked
//   uni_vacated_space    out 10  uni spaces remaining
//   vacated_space        out 10  free-class spaces remaining
//   uni_is_vacated_space out 1   uni space available
//   is_vacated_space     out 1   free-class space available
module parking_controller
    import parking_controller_pkg::*;
#(
    parameter int TOTAL_SPACE = 700,
    parameter int FREE_BASE   = 200,
    parameter int FREE_STEP   = 50
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             car_entered,
    input  logic             is_uni_car_entered,
    input  logic             car_exited,
    input  logic             is_uni_car_exited,
    input  logic [5:0]       current_hour,
    output logic [CNT_W-1:0] uni_parked_car,
    output logic [CNT_W-1:0] parked_car,
    output logic [CNT_W-1:0] uni_vacated_space,
    output logic [CNT_W-1:0] vacated_space,
    output logic             uni_is_vacated_space,
    output logic             is_vacated_space
);
    logic [CNT_W-1:0] free_cap;
    logic [CNT_W-1:0] uni_cap;
    logic             entered_q;
    logic             exited_q;
    logic             enter_ev;
    logic             exit_ev;

    parking_capacity_schedule #(
        .TOTAL_SPACE(TOTAL_SPACE),
        .FREE_BASE  (FREE_BASE),
        .FREE_STEP  (FREE_STEP)
    ) u_schedule (
        .current_hour(current_hour),
        .free_cap    (free_cap),
        .uni_cap     (uni_cap)
    );

    assign enter_ev = car_entered & ~entered_q;
    assign exit_ev  = car_exited & ~exited_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entered_q      <= 1'b0;
            exited_q       <= 1'b0;
            uni_parked_car <= '0;
            parked_car     <= '0;
        end else begin
            entered_q      <= car_entered;
            exited_q       <= car_exited;
            uni_parked_car <= next_count(uni_parked_car, uni_cap,
                                         enter_ev & is_uni_car_entered, exit_ev & is_uni_car_exited);
            parked_car     <= next_count(parked_car, free_cap,
                                         enter_ev & ~is_uni_car_entered, exit_ev & ~is_uni_car_exited);
        end
    end

    always_comb begin
        uni_vacated_space    = sat_sub(uni_cap, uni_parked_car);
        vacated_space        = sat_sub(free_cap, parked_car);
        uni_is_vacated_space = uni_vacated_space != '0;
        is_vacated_space     = vacated_space != '0;
    end
endmodule

// File: tb/tb_parking_controller.sv
// tb_parking_controller: directed vector bench for parking_controller with an 8-space lot
module tb_parking_controller;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       car_entered = 1'b0;
    logic       is_uni_car_entered = 1'b0;
    logic       car_exited = 1'b0;
    logic       is_uni_car_exited = 1'b0;
    logic [5:0] current_hour = 6'd7;
    logic [9:0] uni_parked_car;
    logic [9:0] parked_car;
    logic [9:0] uni_vacated_space;
    logic [9:0] vacated_space;
    logic       uni_is_vacated_space;
    logic       is_vacated_space;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       ent;
        logic       ent_uni;
        logic       ext;
        logic       ext_uni;
        logic [5:0] hour;
        int         uni;
        int         free;
        int         uvac;
        int         vac;
    } vec_t;

    vec_t vecs[$];

    parking_controller #(
        .TOTAL_SPACE(8),
        .FREE_BASE  (3),
        .FREE_STEP  (1)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .car_entered         (car_entered),
        .is_uni_car_entered  (is_uni_car_entered),
        .car_exited          (car_exited),
        .is_uni_car_exited   (is_uni_car_exited),
        .current_hour        (current_hour),
        .uni_parked_car      (uni_parked_car),
        .parked_car          (parked_car),
        .uni_vacated_space   (uni_vacated_space),
        .vacated_space       (vacated_space),
        .uni_is_vacated_space(uni_is_vacated_space),
        .is_vacated_space    (is_vacated_space)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input int uni, input int free, input int uvac, input int vac);
        check({tag, " uni_parked_car"}, int'(uni_parked_car), uni);
        check({tag, " parked_car"}, int'(parked_car), free);
        check({tag, " uni_vacated_space"}, int'(uni_vacated_space), uvac);
        check({tag, " vacated_space"}, int'(vacated_space), vac);
        check({tag, " uni_is_vacated_space"}, int'(uni_is_vacated_space), int'(uvac != 0));
        check({tag, " is_vacated_space"}, int'(is_vacated_space), int'(vac != 0));
    endtask

    task automatic add(input logic e, input logic eu, input logic x, input logic xu, input int h,
                       input int u, input int f, input int uv, input int v);
        vec_t r;
        r.ent = e; r.ent_uni = eu; r.ext = x; r.ext_uni = xu; r.hour = 6'(h);
        r.uni = u; r.free = f; r.uvac = uv; r.vac = v;
        vecs.push_back(r);
    endtask

    initial begin
        // morning split: uni 5, free 3; exits at zero count are ignored
        add(0, 0, 1, 1, 7, 0, 0, 5, 3);
        add(0, 0, 1, 0, 7, 0, 0, 5, 3);
        // fill uni, sixth entry rejected
        add(1, 1, 0, 0, 8, 1, 0, 4, 3);
        add(1, 1, 0, 0, 8, 2, 0, 3, 3);
        add(1, 1, 0, 0, 8, 3, 0, 2, 3);
        add(1, 1, 0, 0, 8, 4, 0, 1, 3);
        add(1, 1, 0, 0, 8, 5, 0, 0, 3);
        add(1, 1, 0, 0, 8, 5, 0, 0, 3);
        // fill free, fourth entry rejected, then one exit
        add(1, 0, 0, 0, 8, 5, 1, 0, 2);
        add(1, 0, 0, 0, 8, 5, 2, 0, 1);
        add(1, 0, 0, 0, 8, 5, 3, 0, 0);
        add(1, 0, 0, 0, 8, 5, 3, 0, 0);
        add(0, 0, 1, 0, 8, 5, 2, 0, 1);
        // hour 14: uni cap 3 below occupancy 5, free cap 5
        add(0, 0, 0, 0, 14, 5, 2, 0, 3);
        add(0, 0, 1, 1, 14, 4, 2, 0, 3);
        add(0, 0, 1, 1, 14, 3, 2, 0, 3);
        add(0, 0, 1, 1, 14, 2, 2, 1, 3);
        // hour 16: uni cap 1, free cap 7
        add(0, 0, 1, 1, 16, 1, 2, 0, 5);
        add(1, 1, 1, 1, 16, 1, 2, 0, 5);
        add(1, 1, 0, 0, 16, 1, 2, 0, 5);
        // different classes in one cycle are independent
        add(1, 0, 1, 1, 16, 0, 3, 1, 4);
        // out-of-range hour behaves like the evening
        add(0, 0, 0, 0, 40, 0, 3, 1, 4);

        // during reset the outputs already follow the schedule
        current_hour = 6'd14;
        repeat (2) @(posedge clk);
        #1;
        check_all("in_reset", 0, 0, 3, 5);
        current_hour = 6'd7;
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_all("after_reset", 0, 0, 5, 3);

        foreach (vecs[i]) begin
            car_entered = vecs[i].ent;
            is_uni_car_entered = vecs[i].ent_uni;
            car_exited = vecs[i].ext;
            is_uni_car_exited = vecs[i].ext_uni;
            current_hour = vecs[i].hour;
            @(posedge clk);
            #1;
            check_all($sformatf("vec%0d", i), vecs[i].uni, vecs[i].free, vecs[i].uvac, vecs[i].vac);
            car_entered = 1'b0;
            car_exited = 1'b0;
            @(posedge clk);
            #1;
        end

        // a level held high counts once
        current_hour = 6'd8;
        car_entered = 1'b1;
        is_uni_car_entered = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check_all("held_entry", 1, 3, 4, 0);
        car_entered = 1'b0;
        @(posedge clk);
        #1;

        // free class full at hour 8: entry with simultaneous exit keeps count
        car_entered = 1'b1;
        is_uni_car_entered = 1'b0;
        car_exited = 1'b1;
        is_uni_car_exited = 1'b0;
        @(posedge clk);
        #1;
        check_all("free_swap_full", 1, 3, 4, 0);
        car_entered = 1'b0;
        car_exited = 1'b0;
        @(posedge clk);
        #1;
        car_entered = 1'b1;
        @(posedge clk);
        #1;
        check_all("free_reject", 1, 3, 4, 0);
        car_entered = 1'b0;

        // asynchronous reset clears counts without a clock edge
        #2;
        rst_n = 1'b0;
        #1;
        check_all("async_reset", 0, 0, 5, 3);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/parking_controller.md
Name: parking_controller

Overview:
- Occupancy controller for a parking lot shared by university ("uni") cars and public ("free") cars.
- Tracks the parked count for each class and derives the remaining spaces from an hour-dependent split of a fixed total capacity.
- Accepts or rejects each entry and exit event, and drives space-available flags for entrance signage.
- Sits between the gate sensors and the display/gate logic.

Parameters:
- TOTAL_SPACE, 700, total number of spaces in the lot.
- FREE_BASE, 200, free-class capacity before 13:00.
- FREE_STEP, 50, free-class capacity added per hour from 13:00 to 16:00.
- Requirement on all parameters: TOTAL_SPACE >= FREE_BASE + 4*FREE_STEP, and TOTAL_SPACE < 1024.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- car_entered  in  1  entry event level; a rising edge marks one entry.
- is_uni_car_entered  in  1  class of the entering car (1 = uni); sampled with car_entered.
- car_exited  in  1  exit event level; a rising edge marks one exit.
- is_uni_car_exited  in  1  class of the exiting car (1 = uni); sampled with car_exited.
- current_hour  in  6  hour of day, 0..23.
- uni_parked_car  out  10  number of uni cars parked.
- parked_car  out  10  number of free-class cars parked (uni cars excluded).
- uni_vacated_space  out  10  free uni spaces remaining.
- vacated_space  out  10  free free-class spaces remaining.
- uni_is_vacated_space  out  1  uni_vacated_space != 0.
- is_vacated_space  out  1  vacated_space != 0.

Behaviour:
- Reset: both counts clear to 0 and the edge-detect registers clear to 0.
  - During reset the vacated outputs equal the current capacities; the flags are 1.
- Edge detection: car_entered and car_exited are each registered. An event occurs in the cycle where the input is 1 and its registered value is 0.
  - A level held high for many cycles counts exactly once.
  - The class bit is sampled in the event cycle.
- Capacity schedule (combinational from current_hour; h = current_hour):
  - h < 13: free_cap = FREE_BASE.
  - 13 <= h <= 15: free_cap = FREE_BASE + FREE_STEP*(h-12).
  - h >= 16 (including out-of-range values 24..63): free_cap = FREE_BASE + 4*FREE_STEP.
  - uni_cap = TOTAL_SPACE - free_cap in all cases.
  - Hours before 08:00 use the morning split.
- Entry event: the count for the car's class increments if that count < the class capacity. Otherwise the entry is rejected and the count is unchanged.
- Exit event: the count for the car's class decrements if nonzero. An exit from a zero count is ignored; the count never wraps.
- Simultaneous entry and exit in one cycle: both are evaluated against the pre-cycle counts.
  - A same-class entry at full capacity is accepted when a same-class exit is accepted in that cycle; the count stays unchanged.
  - Different classes are updated independently.
- Latency: counts update on the clock edge that ends the event cycle.
- Vacated outputs and flags are combinational from the registered counts and current_hour.
- Vacated arithmetic: vacated = cap - count, saturating at 0.
  - When the schedule shrinks a class below its current occupancy, no car is evicted; that class's vacated output reads 0 until enough exits bring the count below capacity.
- All arithmetic is 10-bit unsigned.

Decomposition:
- Shared package:
  - hour constants SHIFT_START_HOUR = 13 and SHIFT_END_HOUR = 16.
  - count width constant CNT_W = 10.
- One natural sub-module: parking_capacity_schedule.
  - Purely combinational: current_hour to free_cap and uni_cap.
  - Parameterised like the top level.
- The top level holds the edge detectors, the two counters and the saturating subtractors.

Test Plan:
- Parameters (8,3,1), hour 7, after reset -> both counts 0, uni_vacated_space 5, vacated_space 3, both flags 1. A uni exit and a free exit here leave both counts at 0.
- Hour 8: 6 uni entries, each a separate rising edge -> uni_parked_car 5, uni_vacated_space 0, uni_is_vacated_space 0. The sixth entry is rejected.
- Hour 8: car_entered held high for 10 cycles with the uni class -> uni_parked_car increments by exactly 1.
- Hour 8: 4 free entries -> parked_car 3, is_vacated_space 0. Then 1 free exit -> parked_car 2, vacated_space 1.
- Uni full (5) at hour 8, then current_hour 14 (uni_cap 3) -> uni_vacated_space 0, uni_parked_car still 5. After 3 uni exits -> count 2, uni_vacated_space 1.
- Hour 16 (free_cap 7, uni_cap 1), uni count 1: simultaneous uni entry and uni exit -> uni_parked_car stays 1. A following lone uni entry is rejected.
